// File: rtl/note_pkg.sv
// Shared note table and FSM encodings for the note square-wave link.
// The generator and the detector read the same table, so their timings cannot drift apart.
package note_pkg;

  localparam int NUM_NOTES = 10;
  localparam int NOTE_W    = 4;
  localparam int HALF_W    = 16;

  localparam logic [HALF_W-1:0] REAL_HALF [NUM_NOTES] = '{
    16'd47710, 16'd42517, 16'd35817, 16'd31888, 16'd28409,
    16'd23901, 16'd21295, 16'd17908, 16'd15944, 16'd14205
  };

  localparam logic [HALF_W-1:0] SIM_HALF [NUM_NOTES] = '{
    16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12
  };

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  function automatic logic [HALF_W-1:0] table_half(input logic use_sim, input int idx);
    return use_sim ? SIM_HALF[idx] : REAL_HALF[idx];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input, plus a one-cycle pulse
// on every transition of the synchronized level (both polarities).
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic toggled
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= d_async;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign toggled = sync_p1 ^ sync_p2;

endmodule

// File: rtl/note_detector.sv
// Measures the half-period of an incoming square wave and locks onto the matching
// entry of the shared note table once enough consecutive half-periods agree.
module note_detector
  import note_pkg::*;
#(
  parameter int              USE_SIM_TABLE = 0,
  parameter int              TOL           = 16,
  parameter int              LOCK_COUNT    = 4,
  parameter logic [HALF_W-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sound_in,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              note_changed,
  output logic [HALF_W-1:0] half_period
);

  localparam int              LCW      = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_COUNT);

  function automatic logic [HALF_W:0] abs_diff(input logic [HALF_W-1:0] a,
                                               input logic [HALF_W-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  state_t              state, state_nxt;
  logic                tone_edge;
  logic [HALF_W-1:0]   cnt;
  logic [NOTE_W-1:0]   cand;
  logic [LCW-1:0]      lock_cnt, lock_nxt;
  logic                match_hit, lock_hit;
  logic [NOTE_W-1:0]   match_idx;

  edge_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (sound_in),
    .toggled (tone_edge)
  );

  // cnt already holds the exact edge-to-edge distance in the cycle of the edge
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (abs_diff(cnt, table_half(USE_SIM_TABLE != 0, i)) <= (HALF_W+1)'(TOL)) begin
        match_hit = 1'b1;
        match_idx = NOTE_W'(i);
      end
    end
  end

  always_comb begin
    lock_nxt = lock_cnt;
    if (!match_hit)
      lock_nxt = '0;
    else if (match_idx == cand)
      lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
    else
      lock_nxt = LCW'(1);
    lock_hit = match_hit && (lock_nxt == LOCK_MAX) && (!note_valid || match_idx == note);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable && tone_edge) state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (!enable)
          state_nxt = S_IDLE;
        else if (!tone_edge && cnt == TIMEOUT)
          state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Measurement and lock tracking; an edge wins over a coincident timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      cand         <= '0;
      lock_cnt     <= '0;
      note         <= '0;
      note_valid   <= 1'b0;
      note_changed <= 1'b0;
      half_period  <= '0;
    end else begin
      note_changed <= 1'b0;
      if (state == S_IDLE) begin
        if (enable && tone_edge) cnt <= HALF_W'(1);
      end else if (!enable) begin
        note_valid <= 1'b0;
        lock_cnt   <= '0;
      end else if (tone_edge) begin
        cnt         <= HALF_W'(1);
        half_period <= cnt;
        lock_cnt    <= lock_nxt;
        if (match_hit) cand <= match_idx;
        if (lock_hit) begin
          note_valid   <= 1'b1;
          note         <= match_idx;
          note_changed <= !note_valid;
        end else begin
          note_valid <= 1'b0;
        end
      end else if (cnt == TIMEOUT) begin
        note_valid <= 1'b0;
        lock_cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: one sim-table instance for lock/timeout/enable/reset behaviour,
// two real-table instances for tolerance boundaries; expectations are queued with a due cycle.
module tb_note_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_r, en_a;
  logic        snd [3];
  logic [3:0]  note_o [3];
  logic        valid_o [3];
  logic        chg_o [3];
  logic [15:0] hp_o [3];

  note_detector #(.USE_SIM_TABLE(1), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(16'd64)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .sound_in(snd[0]),
    .note(note_o[0]), .note_valid(valid_o[0]), .note_changed(chg_o[0]), .half_period(hp_o[0]));

  note_detector #(.USE_SIM_TABLE(0), .TOL(16), .LOCK_COUNT(1), .TIMEOUT(16'hFFFF)) dut_b (
    .clk(clk), .reset(rst_r), .enable(1'b1), .sound_in(snd[1]),
    .note(note_o[1]), .note_valid(valid_o[1]), .note_changed(chg_o[1]), .half_period(hp_o[1]));

  note_detector #(.USE_SIM_TABLE(0), .TOL(16), .LOCK_COUNT(1), .TIMEOUT(16'hFFFF)) dut_c (
    .clk(clk), .reset(rst_r), .enable(1'b1), .sound_in(snd[2]),
    .note(note_o[2]), .note_valid(valid_o[2]), .note_changed(chg_o[2]), .half_period(hp_o[2]));

  typedef struct {
    int          dut;
    int          due;
    logic [15:0] hp;
    logic        v;
    logic [3:0]  n;
    logic        c;
    string       tag;
  } exp_t;

  typedef struct {
    int          gap;
    logic [15:0] hp;
    logic        v;
    logic [3:0]  n;
    logic        c;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   pulses_a = 0;
  int   exp_pulses = 0;
  int   t_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chg_o[0] === 1'b1) pulses_a++;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        check({sbq[i].tag, "/half_period"}, 32'(hp_o[sbq[i].dut]), 32'(sbq[i].hp));
        check({sbq[i].tag, "/note_valid"}, 32'(valid_o[sbq[i].dut]), 32'(sbq[i].v));
        check({sbq[i].tag, "/note"}, 32'(note_o[sbq[i].dut]), 32'(sbq[i].n));
        check({sbq[i].tag, "/note_changed"}, 32'(chg_o[sbq[i].dut]), 32'(sbq[i].c));
        sbq.delete(i);
      end
    end
  end

  task automatic push(input int d, input int due, input int hp, input bit v, input int n, input bit c);
    sbq.push_back('{d, due, 16'(hp), v, 4'(n), c, $sformatf("dut%0d@%0d", d, due)});
  endtask

  // Toggle after gap cycles; outputs settle 3 cycles after the transition
  task automatic toggle(input int d, input int gap, input int hp, input bit v, input int n, input bit c);
    repeat (gap) @(posedge clk);
    #1;
    snd[d] = ~snd[d];
    push(d, cyc + 3, hp, v, n, c);
  endtask

  task automatic add(input int gap, input int hp, input bit v, input int n, input bit c);
    tbl.push_back('{gap, 16'(hp), v, 4'(n), c});
  endtask

  task automatic add_run(input int gap, input int reps, input int n_hold);
    for (int k = 0; k < reps; k++) add(gap, gap, 1'b0, n_hold, 1'b0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, want completion before 90000", cyc);
    $fatal(1);
  end

  initial begin
    add(5, 0, 0, 0, 0);
    add_run(7, 3, 0);  add(7, 7, 1, 4, 1);   add(7, 7, 1, 4, 0);
    add_run(10, 3, 4); add(10, 10, 1, 7, 1); add(10, 10, 1, 7, 0);
    add(15, 15, 0, 7, 0); add(2, 2, 0, 7, 0);
    add_run(3, 3, 7); add(20, 20, 0, 7, 0);
    add_run(3, 3, 7); add(3, 3, 1, 0, 1);
    add_run(12, 3, 0); add(12, 12, 1, 9, 1);
    foreach (tbl[i]) exp_pulses += int'(tbl[i].c);

    rst_a = 1'b1; rst_r = 1'b1; en_a = 1'b1;
    snd[0] = 1'b0; snd[1] = 1'b0; snd[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/note", 32'(note_o[0]), 0);
    check("reset/note_valid", 32'(valid_o[0]), 0);
    check("reset/note_changed", 32'(chg_o[0]), 0);
    check("reset/half_period", 32'(hp_o[0]), 0);
    check("reset/b_valid", 32'(valid_o[1]), 0);
    rst_a = 1'b0; rst_r = 1'b0;

    fork
      begin
        foreach (tbl[i]) toggle(0, tbl[i].gap, tbl[i].hp, tbl[i].v, tbl[i].n, tbl[i].c);
        t_last = cyc;
        push(0, t_last + 66, 12, 1, 9, 0);
        push(0, t_last + 67, 12, 0, 9, 0);
        repeat (6) @(posedge clk);
        #1;
        check("table/pulse_count", 32'(pulses_a), 32'(exp_pulses));
        while (cyc < t_last + 75) @(posedge clk);

        toggle(0, 7, 12, 0, 9, 0);
        for (int k = 0; k < 3; k++) toggle(0, 7, 7, 0, 9, 0);
        toggle(0, 7, 7, 1, 4, 1);

        repeat (4) @(posedge clk);
        #1;
        en_a = 1'b0;
        push(0, cyc + 1, 7, 0, 4, 0);
        repeat (10) @(posedge clk);
        #1;
        en_a = 1'b1;
        toggle(0, 7, 7, 0, 4, 0);
        for (int k = 0; k < 3; k++) toggle(0, 7, 7, 0, 4, 0);
        toggle(0, 7, 7, 1, 4, 1);
        repeat (4) @(posedge clk);
        #1;
        check("relock/pulse_count", 32'(pulses_a), 32'(exp_pulses + 2));

        @(posedge clk);
        #3;
        rst_a = 1'b1;
        snd[0] = 1'b0;
        #1;
        check("async_reset/note", 32'(note_o[0]), 0);
        check("async_reset/note_valid", 32'(valid_o[0]), 0);
        check("async_reset/half_period", 32'(hp_o[0]), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        toggle(0, 6, 0, 0, 0, 0);
        toggle(0, 6, 6, 0, 0, 0);
      end
      begin
        toggle(1, 10, 0, 0, 0, 0);
        toggle(1, 47725, 47725, 1, 0, 1);
        toggle(1, 14221, 14221, 0, 0, 0);
      end
      begin
        toggle(2, 10, 0, 0, 0, 0);
        toggle(2, 47800, 47800, 0, 0, 0);
        toggle(2, 14189, 14189, 1, 9, 1);
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
